// File: rtl/reg_ctrl_pkg.sv
// reg_ctrl_pkg: shared types and constants for the register load arbiter
// Contents: state_t (IDLE/LOAD/HOLD), NUM_REQ requester count, PTR_W pointer width
package reg_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
    localparam int NUM_REQ = 4;
    localparam int PTR_W   = $clog2(NUM_REQ);
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select starting at ptr
// Ports: req - level requests; ptr - highest-priority index;
//        valid - any request present; win - winning requester index
module rr_pick
    import reg_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   win
);
    always_comb begin
        valid = |req;
        win   = ptr;
        // scan farthest-first so the nearest requester at or after ptr wins
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[ptr + PTR_W'(i)]) win = ptr + PTR_W'(i);
    end
endmodule

// File: rtl/reg_load_arbiter.sv
// reg_load_arbiter: round-robin sharing of one loadable register among four requesters
// Ports: clk - clock; clr - async active-high reset; req - level requests;
//        d0..d3 - requester data; load - one-cycle register load strobe;
//        d_out - data to register; gnt - one-hot grant; done - last hold cycle;
//        busy - high during load and hold
module reg_load_arbiter
    import reg_ctrl_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NUM_REQ-1:0] req,
    input  logic [WIDTH-1:0]   d0,
    input  logic [WIDTH-1:0]   d1,
    input  logic [WIDTH-1:0]   d2,
    input  logic [WIDTH-1:0]   d3,
    output logic               load,
    output logic [WIDTH-1:0]   d_out,
    output logic [NUM_REQ-1:0] gnt,
    output logic               done,
    output logic               busy
);
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    state_t           state, state_nx;
    logic [PTR_W-1:0] ptr, win, pick;
    logic             valid;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] d_sel;

    rr_pick u_pick (.req(req), .ptr(ptr), .valid(valid), .win(pick));

    assign d_sel = pick == 2'd0 ? d0 : pick == 2'd1 ? d1 : pick == 2'd2 ? d2 : d3;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_nx;
    end

    // hold exit is tested before any decrement, so cnt never wraps
    always_comb begin
        state_nx = state == IDLE ? (valid ? LOAD : IDLE) :
                   state == LOAD ? HOLD :
                   cnt == '0     ? IDLE : HOLD;
        load     = state == LOAD;
        done     = state == HOLD && cnt == '0;
        busy     = state != IDLE;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            gnt   <= '0;
            d_out <= '0;
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (valid) begin
                    gnt   <= NUM_REQ'(1) << pick;
                    d_out <= d_sel;
                    win   <= pick;
                end
                LOAD: begin
                    ptr <= win + 1'b1;
                    cnt <= CW'(HOLD_CYCLES - 1);
                end
                HOLD: if (cnt == '0) begin
                    gnt   <= '0;
                    d_out <= '0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_load_arbiter.sv
// tb_reg_load_arbiter: randomized check of two arbiter instances (hold 4 and hold 1) against a grant-window model
module tb_reg_load_arbiter;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic       load_a, done_a, busy_a, load_b, done_b, busy_b;
    logic [3:0] gnt_a, gnt_b, dout_a, dout_b;
    int         n_tests = 0, n_fail = 0;
    int         m_left[2], m_ptr[2], m_win[2];
    logic [3:0] m_data[2];

    reg_load_arbiter #(.WIDTH(4), .HOLD_CYCLES(4)) dut_a (
        .clk(clk), .clr(clr), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .load(load_a), .d_out(dout_a), .gnt(gnt_a), .done(done_a), .busy(busy_a));

    reg_load_arbiter #(.WIDTH(4), .HOLD_CYCLES(1)) dut_b (
        .clk(clk), .clr(clr), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .load(load_b), .d_out(dout_b), .gnt(gnt_b), .done(done_b), .busy(busy_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int hold_of(input int k);
        return k == 0 ? 4 : 1;
    endfunction

    function automatic logic [3:0] data_of(input int i);
        return i == 0 ? d0 : i == 1 ? d1 : i == 2 ? d2 : d3;
    endfunction

    // a grant occupies a window of hold+1 cycles (load cycle, then hold);
    // the edge that closes a window never starts a new one
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (m_left[k] > 0) m_left[k]--;
            else if (req != 0) begin
                for (int i = 0; i < 4; i++)
                    if (m_left[k] == 0 && req[(m_ptr[k] + i) % 4]) begin
                        m_win[k]  = (m_ptr[k] + i) % 4;
                        m_data[k] = data_of(m_win[k]);
                        m_ptr[k]  = (m_win[k] + 1) % 4;
                        m_left[k] = hold_of(k) + 1;
                    end
            end
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_ptr[k]  = 0;
            m_win[k]  = 0;
            m_data[k] = '0;
        end
    endtask

    task automatic check_all();
        logic b;
        b = m_left[0] > 0;
        check("a.busy", busy_a, b);
        check("a.load", load_a, m_left[0] == hold_of(0) + 1);
        check("a.done", done_a, m_left[0] == 1);
        check("a.gnt", gnt_a, b ? 4'(1 << m_win[0]) : 4'h0);
        check("a.d_out", dout_a, b ? m_data[0] : 4'h0);
        b = m_left[1] > 0;
        check("b.busy", busy_b, b);
        check("b.load", load_b, m_left[1] == hold_of(1) + 1);
        check("b.done", done_b, m_left[1] == 1);
        check("b.gnt", gnt_b, b ? 4'(1 << m_win[1]) : 4'h0);
        check("b.d_out", dout_b, b ? m_data[1] : 4'h0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".a"}, {load_a, dout_a, gnt_a, done_a, busy_a}, 0);
        check({tag, ".b"}, {load_b, dout_b, gnt_b, done_b, busy_b}, 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // asynchronous clear between edges; outputs must drop before any clock
    task automatic do_clr();
        #2 clr = 1'b1;
        #1 check_zero("clr_async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        clr = 1'b0;
        req = 4'b0001; d0 = 4'hA;
        cycle();
        req = '0;
        repeat (8) cycle();
        req = 4'b1111; d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
        repeat (32) cycle();
        req = 4'b0011;
        repeat (20) cycle();
        req = '0;
        repeat (6) cycle();
        req = 4'b0001; d0 = 4'h5;
        cycle();
        req = '0;
        repeat (2) cycle();
        d0 = 4'hC;
        repeat (6) cycle();
        req = 4'b0100;
        repeat (4) cycle();
        do_clr();
        repeat (10) cycle();
        req = 4'b1000;
        repeat (12) cycle();
        repeat (500) begin
            req = $urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom);
            d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
            if ($urandom_range(0, 40) == 0) do_clr();
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_load_arbiter.md
# reg_load_arbiter

Round-robin controller that shares one 4-bit loadable register (load/d/q, clear on `clr`) between four requesters. It arbitrates requests, drives the register's `load` strobe and data for exactly one cycle per grant, then holds the grant for a programmable display interval (nominally one second at board clock) before serving the next requester. It sits between the requester logic and the register instance at the top level.

## Interface
Parameters:
- `WIDTH`, 4: data width of the shared register.
- `HOLD_CYCLES`, 4: cycles the grant is held after the load. Must be ≥1. Board value is the 1 Hz period in `clk` cycles; the default is for simulation.

Ports:
- `clk` in 1: system clock. All logic is rising-edge.
- `clr` in 1: asynchronous, active-high reset.
- `req` in 4: level request, bit i for requester i.
- `d0`, `d1`, `d2`, `d3` in WIDTH each: requester data.
- `load` out 1: one-cycle load strobe to the register.
- `d_out` out WIDTH: data to the register `d` input.
- `gnt` out 4: one-hot grant.
- `done` out 1: one-cycle pulse in the final HOLD cycle.
- `busy` out 1: high in LOAD and HOLD.

## Operation
- States: IDLE, LOAD, HOLD.
- IDLE: if any `req` bit is set, pick a winner by round-robin from pointer `ptr` (2 bits). Search order is `ptr`, `ptr+1`, … mod 4. Register `gnt` and `d_out` from the winner's data, then go to LOAD. If no request is set, stay in IDLE with all outputs 0.
- LOAD: `load`=1 for exactly this cycle. Set `ptr` to winner+1 (mod 4). Load the hold counter with `HOLD_CYCLES-1`, then go to HOLD.
- HOLD: decrement the counter each cycle. When the counter is 0, assert `done` and go to IDLE.
- `gnt`, `d_out` and `busy` are stable from LOAD through the last HOLD cycle. They clear on entry to IDLE, where `d_out` returns to 0.
- `d_out` is captured once at arbitration. Changes on `dN` after that are ignored.
- Once a grant is issued, `req` is not re-sampled. Dropping `req` mid-HOLD does not shorten the hold.
- New requests arriving during LOAD or HOLD wait. They are evaluated in the next IDLE cycle.
- Simultaneous requests resolve strictly by the pointer. No requester is starved: the maximum wait is 3 full grant periods.
- `clr` at any time, including mid-HOLD: state→IDLE, `ptr`→0, counter→0, and all outputs→0 immediately (asynchronous). The register itself is cleared by the same `clr`.

## Timing
- Reset values: `load`=0, `d_out`=0, `gnt`=0, `done`=0, `busy`=0.
- Request seen high in IDLE at edge T: LOAD occupies cycle T+1, and the register `q` shows the data after edge T+2.
- HOLD occupies cycles T+2 … T+1+HOLD_CYCLES. `done` is asserted in cycle T+1+HOLD_CYCLES.
- There is a minimum of one IDLE cycle between grants. Grant period is HOLD_CYCLES+2 cycles back-to-back.
- With `HOLD_CYCLES`=1: HOLD lasts one cycle, and `done` coincides with the single HOLD cycle.
- The counter is `$clog2(HOLD_CYCLES)` bits wide, minimum 1 bit. The counter never wraps: the exit at 0 is checked before the decrement.

## Structure
- Package `reg_ctrl_pkg` holds:
  - the state enum (IDLE, LOAD, HOLD);
  - `NUM_REQ`=4;
  - the pointer width constant.
- One combinational sub-module, `rr_pick`:
  - inputs: `req[3:0]`, `ptr[1:0]`;
  - outputs: `valid` and a 2-bit winner index.
- The FSM, counter, pointer and output registers live in `reg_load_arbiter`.

## Test plan
All scenarios use `HOLD_CYCLES`=4 unless noted.
- Single request: `req`=0001, `d0`=4'hA, then drop `req`. Expect `load`=1 for one cycle, `gnt`=0001 for 5 cycles, `q`=4'hA, one `done` pulse, return to IDLE.
- All four requests held: `req`=1111, `d0..d3`=1,2,3,4. Expect grants in order 0,1,2,3,0, a 6-cycle period, and `q` sequence 1,2,3,4,1.
- Fairness: `req`=0011 held. Expect alternating `gnt` 0001, 0010, 0001. Requester 0 never receives two grants in a row.
- Data change after grant: `d0` goes 4'h5→4'hC during HOLD. Expect `d_out` and `q` to stay 4'h5.
- `clr` pulse mid-HOLD with `req`=0100. Expect all outputs 0 immediately and `ptr`=0. After release, requester 2 is granted again after 1 IDLE cycle.
- `HOLD_CYCLES`=1 with `req`=1000 held. Expect a 3-cycle grant period, `done` every 3rd cycle, and `load` never asserted in consecutive cycles.
